rx_reset_seq: RTL and testbench

- Parametrised, per-channel receive-side transceiver reset sequencer for the serdes data-input path.
- Generalised successor to the fixed 5-lane PHY RX reset controller.
- Each of NUM_CH channels runs an independent FSM: analog reset → calibration wait → lock qualification → digital reset → ready.
- Adds lock-loss recovery, lock timeout with bounded retry, per-channel software reset, failure flag and retry counters for status registers.

---
 rtl/rx_reset_seq.sv | 182 ++++++++++++++++++
 tb/tb_rx_reset_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rx_reset_seq.sv
// rx_reset_seq: per-channel RX transceiver reset sequencer. Each channel steps through analog reset, calibration wait, lock qualification and digital reset to ready, and retries a bounded number of times on lock timeout.
// Latency: the lock and calibration inputs pass through a 2-flop synchroniser. Outputs are registered and follow the state one cycle after the decision.
// Backpressure: none. Each channel is paced only by its synchronised PHY status and its own rx_ch_reset.
// Ports: clock/reset (sync, active-high); rx_ch_reset, rx_is_lockedtodata, rx_cal_busy in [NUM_CH];
//        rx_analogreset, rx_digitalreset, rx_ready, rx_fail out [NUM_CH]; rx_retry_cnt out [NUM_CH*RETRY_W].
module rx_reset_seq #(
  parameter int NUM_CH       = 5,
  parameter int T_ANALOG     = 8,
  parameter int T_LTD        = 16,
  parameter int T_DIGITAL    = 4,
  parameter int LOCK_TIMEOUT = 64,
  parameter int MAX_RETRY    = 3,
  parameter int RETRY_W      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           rx_ch_reset,
  input  logic [NUM_CH-1:0]           rx_is_lockedtodata,
  input  logic [NUM_CH-1:0]           rx_cal_busy,
  output logic [NUM_CH-1:0]           rx_analogreset,
  output logic [NUM_CH-1:0]           rx_digitalreset,
  output logic [NUM_CH-1:0]           rx_ready,
  output logic [NUM_CH-1:0]           rx_fail,
  output logic [NUM_CH*RETRY_W-1:0]   rx_retry_cnt
);

  // One counter width serves every phase; it only ever holds (limit - 1).
  localparam int M1      = (T_ANALOG > T_LTD) ? T_ANALOG : T_LTD;
  localparam int M2      = (T_DIGITAL > LOCK_TIMEOUT) ? T_DIGITAL : LOCK_TIMEOUT;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (MAX_RETRY < 1) begin : g_bad_max_retry
    $error("rx_reset_seq: MAX_RETRY must be at least 1");
  end
  if (T_ANALOG < 1 || T_LTD < 1 || T_DIGITAL < 1 || LOCK_TIMEOUT < 1) begin : g_bad_timing
    $error("rx_reset_seq: T_ANALOG, T_LTD, T_DIGITAL and LOCK_TIMEOUT must be at least 1");
  end
  if (MAX_RETRY > (2 ** RETRY_W) - 1) begin : g_bad_retry_w
    $error("rx_reset_seq: RETRY_W too narrow to hold MAX_RETRY");
  end

  typedef enum logic [2:0] {
    ST_ANALOG, ST_WAIT_CAL, ST_WAIT_LOCK, ST_DIGITAL, ST_READY, ST_FAIL
  } state_t;

  // Two-flop synchronisers for the asynchronous PHY status inputs.
  logic [NUM_CH-1:0] lock_m_q, lock_s_q, cal_m_q, cal_s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_m_q <= '0;
      lock_s_q <= '0;
      cal_m_q  <= '0;
      cal_s_q  <= '0;
    end else begin
      lock_m_q <= rx_is_lockedtodata;
      lock_s_q <= lock_m_q;
      cal_m_q  <= rx_cal_busy;
      cal_s_q  <= cal_m_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, stab_q, stab_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               ana_q, dig_q, rdy_q, fail_q;
    logic               lock_s, cal_s;

    assign lock_s    = lock_s_q[i];
    assign cal_s     = cal_s_q[i];
    assign retry_inc = (retry_q == {RETRY_W{1'b1}}) ? retry_q : retry_q + 1'b1;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stab_d  = stab_q;
      retry_d = retry_q;
      if (rx_ch_reset[i]) begin
        // Held request keeps cnt at 0, so the analog count starts after release.
        state_d = ST_ANALOG;
        cnt_d   = '0;
        stab_d  = '0;
        retry_d = '0;
      end else begin
        case (state_q)
          ST_ANALOG: begin
            if (cnt_q == CNT_W'(T_ANALOG - 1)) begin
              state_d = ST_WAIT_CAL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_WAIT_CAL: begin
            if (!cal_s) begin
              state_d = ST_WAIT_LOCK;
              cnt_d   = '0;
              stab_d  = '0;
            end
          end
          ST_WAIT_LOCK: begin
            cnt_d  = cnt_q + 1'b1;
            stab_d = lock_s ? stab_q + 1'b1 : '0;
            // Qualification is tested first so it wins a tie with the timeout.
            if (lock_s && stab_q == CNT_W'(T_LTD - 1)) begin
              state_d = ST_DIGITAL;
              cnt_d   = '0;
              stab_d  = '0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
              retry_d = retry_inc;
              cnt_d   = '0;
              stab_d  = '0;
              state_d = (retry_inc >= RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_ANALOG;
            end
          end
          ST_DIGITAL: begin
            if (!lock_s) begin
              state_d = ST_WAIT_LOCK;
              cnt_d   = '0;
              stab_d  = '0;
            end else if (cnt_q == CNT_W'(T_DIGITAL - 1)) begin
              state_d = ST_READY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_READY: begin
            // Recalibration outranks lock loss: the CDR is expected to drop during cal.
            if (cal_s) begin
              state_d = ST_WAIT_CAL;
            end else if (!lock_s) begin
              state_d = ST_WAIT_LOCK;
              cnt_d   = '0;
              stab_d  = '0;
            end
          end
          ST_FAIL: begin
            state_d = ST_FAIL;
          end
          default: begin
            state_d = ST_ANALOG;
            cnt_d   = '0;
            stab_d  = '0;
          end
        endcase
      end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= ST_ANALOG;
        cnt_q   <= '0;
        stab_q  <= '0;
        retry_q <= '0;
        ana_q   <= 1'b1;
        dig_q   <= 1'b1;
        rdy_q   <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        stab_q  <= stab_d;
        retry_q <= retry_d;
        ana_q   <= (state_d == ST_ANALOG) || (state_d == ST_FAIL);
        dig_q   <= (state_d != ST_READY);
        rdy_q   <= (state_d == ST_READY);
        fail_q  <= (state_d == ST_FAIL);
      end
    end

    assign rx_analogreset[i]                   = ana_q;
    assign rx_digitalreset[i]                  = dig_q;
    assign rx_ready[i]                         = rdy_q;
    assign rx_fail[i]                          = fail_q;
    assign rx_retry_cnt[i*RETRY_W +: RETRY_W]  = retry_q;
  end

endmodule

// File: tb/tb_rx_reset_seq.sv
// tb_rx_reset_seq: directed-vector bench for rx_reset_seq with default parameters.
// Cycle n is the interval after the n-th active edge following reset release; checks sample 1 ns after the edge.
// Inputs change at the same sample point, so they are seen by the edge that ends the current cycle.
module tb_rx_reset_seq;
  localparam int NUM_CH  = 5;
  localparam int RETRY_W = 4;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_CH-1:0]         rx_ch_reset = '0;
  logic [NUM_CH-1:0]         rx_is_lockedtodata = '1;
  logic [NUM_CH-1:0]         rx_cal_busy = '0;
  logic [NUM_CH-1:0]         rx_analogreset;
  logic [NUM_CH-1:0]         rx_digitalreset;
  logic [NUM_CH-1:0]         rx_ready;
  logic [NUM_CH-1:0]         rx_fail;
  logic [NUM_CH*RETRY_W-1:0] rx_retry_cnt;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  rx_reset_seq dut (
    .clock              (clock),
    .reset              (reset),
    .rx_ch_reset        (rx_ch_reset),
    .rx_is_lockedtodata (rx_is_lockedtodata),
    .rx_cal_busy        (rx_cal_busy),
    .rx_analogreset     (rx_analogreset),
    .rx_digitalreset    (rx_digitalreset),
    .rx_ready           (rx_ready),
    .rx_fail            (rx_fail),
    .rx_retry_cnt       (rx_retry_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    // ---------------- Power-up, all channels locked ----------------
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_analog", 32'(rx_analogreset), 32'h1f);
    chk("rst_digital", 32'(rx_digitalreset), 32'h1f);
    chk("rst_ready", 32'(rx_ready), 32'h0);
    chk("rst_fail", 32'(rx_fail), 32'h0);
    chk("rst_retry", 32'(rx_retry_cnt), 32'h0);
    reset = 1'b0;
    cyc = 0;
    run_to(7);  chk("pu_analog_c7", 32'(rx_analogreset), 32'h1f);
    run_to(8);  chk("pu_analog_c8", 32'(rx_analogreset), 32'h00);
                chk("pu_digital_c8", 32'(rx_digitalreset), 32'h1f);
    run_to(28); chk("pu_ready_c28", 32'(rx_ready), 32'h00);
                chk("pu_digital_c28", 32'(rx_digitalreset), 32'h1f);
    run_to(29); chk("pu_ready_c29", 32'(rx_ready), 32'h1f);
                chk("pu_digital_c29", 32'(rx_digitalreset), 32'h00);

    // ---------------- Second run: ch4 never locks ----------------
    rx_is_lockedtodata = 5'b01111;
    reset = 1'b1;
    tick();
    chk("rerst_analog", 32'(rx_analogreset), 32'h1f);
    chk("rerst_ready", 32'(rx_ready), 32'h00);
    tick();
    reset = 1'b0;
    cyc = 0;

    // Lock glitch on ch2.
    run_to(20); rx_is_lockedtodata[2] = 1'b0;
    run_to(21); rx_is_lockedtodata[2] = 1'b1;
    run_to(29); chk("glitch_ready_c29", 32'(rx_ready), 32'h0b);
    run_to(42); chk("glitch_ready_c42", 32'(rx_ready), 32'h0b);
    run_to(43); chk("glitch_ready_c43", 32'(rx_ready), 32'h0f);

    // Lock loss on ch0 while ready.
    run_to(50); rx_is_lockedtodata[0] = 1'b0;
    run_to(52); chk("loss_ready_c52", 32'(rx_ready), 32'h0f);
    run_to(53); chk("loss_ready_c53", 32'(rx_ready), 32'h0e);
                chk("loss_digital_c53", 32'(rx_digitalreset), 32'h11);
    run_to(60); rx_is_lockedtodata[0] = 1'b1;

    // First ch4 timeout.
    run_to(72); chk("to1_retry_c72", 32'(rx_retry_cnt), 32'h00000);
                chk("to1_analog_c72", 32'(rx_analogreset), 32'h00);
    run_to(73); chk("to1_retry_c73", 32'(rx_retry_cnt), 32'h10000);
                chk("to1_analog_c73", 32'(rx_analogreset), 32'h10);

    run_to(81); chk("relock_ready_c81", 32'(rx_ready), 32'h0e);
    run_to(82); chk("relock_ready_c82", 32'(rx_ready), 32'h0f);
                chk("relock_digital_c82", 32'(rx_digitalreset), 32'h10);
                chk("relock_retry_c82", 32'(rx_retry_cnt), 32'h10000);

    // Calibration on ch1 while ready.
    run_to(100); rx_cal_busy[1] = 1'b1;
    run_to(102); chk("cal_ready_c102", 32'(rx_ready), 32'h0f);
    run_to(103); chk("cal_ready_c103", 32'(rx_ready), 32'h0d);
                 chk("cal_digital_c103", 32'(rx_digitalreset), 32'h12);
                 chk("cal_analog_c103", 32'(rx_analogreset), 32'h00);
    run_to(110); rx_cal_busy[1] = 1'b0;
                 chk("cal_analog_c110", 32'(rx_analogreset), 32'h00);
                 chk("cal_digital_c110", 32'(rx_digitalreset), 32'h12);
    run_to(132); chk("cal_ready_c132", 32'(rx_ready), 32'h0d);
    run_to(133); chk("cal_ready_c133", 32'(rx_ready), 32'h0f);
                 chk("cal_digital_c133", 32'(rx_digitalreset), 32'h10);

    // Second and third ch4 timeouts, then FAIL.
    run_to(146); chk("to2_retry_c146", 32'(rx_retry_cnt), 32'h20000);
                 chk("to2_analog_c146", 32'(rx_analogreset), 32'h10);
    run_to(218); chk("to3_retry_c218", 32'(rx_retry_cnt), 32'h20000);
                 chk("to3_fail_c218", 32'(rx_fail), 32'h00);
    run_to(219); chk("to3_retry_c219", 32'(rx_retry_cnt), 32'h30000);
                 chk("to3_fail_c219", 32'(rx_fail), 32'h10);
                 chk("to3_analog_c219", 32'(rx_analogreset), 32'h10);
                 chk("to3_digital_c219", 32'(rx_digitalreset), 32'h10);
                 chk("to3_ready_c219", 32'(rx_ready), 32'h0f);

    // Lock returning does not release FAIL.
    run_to(230); rx_is_lockedtodata[4] = 1'b1;
    run_to(259); chk("hold_fail_c259", 32'(rx_fail), 32'h10);
                 chk("hold_analog_c259", 32'(rx_analogreset), 32'h10);
                 chk("hold_ready_c259", 32'(rx_ready), 32'h0f);

    // One-cycle channel reset recovers ch4.
    run_to(260); rx_ch_reset = 5'b10000;
    run_to(261); rx_ch_reset = 5'b00000;
                 chk("rec_fail_c261", 32'(rx_fail), 32'h00);
                 chk("rec_retry_c261", 32'(rx_retry_cnt), 32'h00000);
                 chk("rec_analog_c261", 32'(rx_analogreset), 32'h10);
    run_to(289); chk("rec_ready_c289", 32'(rx_ready), 32'h0f);
    run_to(290); chk("rec_ready_c290", 32'(rx_ready), 32'h1f);
                 chk("rec_digital_c290", 32'(rx_digitalreset), 32'h00);

    // Channel reset held for three cycles on ch3.
    run_to(300); rx_ch_reset = 5'b01000;
    run_to(301); chk("hold_rst_analog_c301", 32'(rx_analogreset), 32'h08);
                 chk("hold_rst_ready_c301", 32'(rx_ready), 32'h17);
    run_to(303); rx_ch_reset = 5'b00000;
    run_to(310); chk("hold_rst_analog_c310", 32'(rx_analogreset), 32'h08);
    run_to(311); chk("hold_rst_analog_c311", 32'(rx_analogreset), 32'h00);
    run_to(331); chk("hold_rst_ready_c331", 32'(rx_ready), 32'h17);
    run_to(332); chk("hold_rst_ready_c332", 32'(rx_ready), 32'h1f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
